// File: rtl/mux_n_to_1_pipe.sv
// rtl/mux_n_to_1_pipe.sv - N-to-1 mux with a single ready/valid output register.
// Round-robin arbitration (mode_i = 1) is compiled in only with MUX_RR_ARB_EN.
module mux_n_to_1_pipe #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CHANNELS*SIZE-1:0] data_i,
    input  logic [CHANNELS-1:0]      valid_i,
    output logic [CHANNELS-1:0]      ready_o,
    input  logic [SEL_W-1:0]         select_i,
    input  logic                     mode_i,
    output logic [SIZE-1:0]          data_o,
    output logic [SEL_W-1:0]         chan_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    logic [SIZE-1:0]  data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic             valid_q, valid_d;

    logic             load;
    logic             xfer;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [SIZE-1:0]  gnt_data;

`ifdef MUX_RR_ARB_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             hi_found, lo_found;
    logic [SEL_W-1:0] hi_gnt, lo_gnt;
`else
    logic             unused_mode;
    assign unused_mode = mode_i;
`endif

    assign load = !valid_q || ready_i;
    assign xfer = load && gnt_vld;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
`ifdef MUX_RR_ARB_EN
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_gnt   = '0;
        lo_gnt   = '0;
        // Descending scan: the last hit is the lowest index, both overall and at/above ptr.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                lo_found = 1'b1;
                lo_gnt   = SEL_W'(k);
                if (SEL_W'(k) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_gnt   = SEL_W'(k);
                end
            end
        end
        if (mode_i) begin
            gnt_vld = lo_found;
            gnt     = hi_found ? hi_gnt : lo_gnt;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (select_i == SEL_W'(k) && valid_i[k]) begin
                    gnt_vld = 1'b1;
                    gnt     = select_i;
                end
            end
        end
`else
        // An out-of-range select matches no channel and so yields no grant.
        for (int k = 0; k < CHANNELS; k++) begin
            if (select_i == SEL_W'(k) && valid_i[k]) begin
                gnt_vld = 1'b1;
                gnt     = select_i;
            end
        end
`endif
    end

    always_comb begin
        gnt_data = '0;
        ready_o  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt == SEL_W'(k)) begin
                gnt_data = data_i[k*SIZE +: SIZE];
            end
            ready_o[k] = rst_i && load && gnt_vld && (gnt == SEL_W'(k));
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = gnt_data;
            chan_d  = gnt;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

`ifdef MUX_RR_ARB_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
`ifdef MUX_RR_ARB_EN
            ptr_q   <= '0;
`endif
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
`ifdef MUX_RR_ARB_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign data_o  = data_q;
    assign chan_o  = chan_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// tb/tb_mux_n_to_1_pipe.sv - directed vector bench for mux_n_to_1_pipe (4- and 3-channel instances).
module tb_mux_n_to_1_pipe;

    logic        clk;
    logic        rst_n;

    logic [31:0] data4;
    logic [3:0]  valid4;
    logic [3:0]  rdy4;
    logic [1:0]  sel4;
    logic        mode4;
    logic [7:0]  dout4;
    logic [1:0]  chan4;
    logic        vo4;
    logic        ready4;

    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  rdy3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  dout3;
    logic [1:0]  chan3;
    logic        vo3;
    logic        ready3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] sel;
        logic       mode;
        logic [3:0] valid;
        logic [3:0] exp_rdy;
        logic       exp_vo;
        logic [7:0] exp_d;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vt[$];

    mux_n_to_1_pipe #(.SIZE(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .data_i(data4), .valid_i(valid4), .ready_o(rdy4),
        .select_i(sel4), .mode_i(mode4), .data_o(dout4), .chan_o(chan4), .valid_o(vo4),
        .ready_i(ready4)
    );

    mux_n_to_1_pipe #(.SIZE(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk_i(clk), .rst_i(rst_n), .data_i(data3), .valid_i(valid3), .ready_o(rdy3),
        .select_i(sel3), .mode_i(mode3), .data_o(dout3), .chan_o(chan3), .valid_o(vo3),
        .ready_i(ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply4(input logic [1:0] s, input logic m, input logic [3:0] v, input logic r);
        @(negedge clk);
        sel4   = s;
        mode4  = m;
        valid4 = v;
        ready4 = r;
        #1;
    endtask

    task automatic edge_out;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        data4  = {8'h3C, 8'hA5, 8'h21, 8'h10};
        valid4 = 4'b1111;
        sel4   = 2'd0;
        mode4  = 1'b0;
        ready4 = 1'b1;
        data3  = {8'h77, 8'h66, 8'h55};
        valid3 = 3'b000;
        sel3   = 2'd0;
        mode3  = 1'b0;
        ready3 = 1'b1;

        // Fixed-mode table; ready_i held high so load is always 1.
        vt.push_back('{2'd2, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5, 2'd2});
        vt.push_back('{2'd1, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h21, 2'd1});
        vt.push_back('{2'd1, 1'b0, 4'b1101, 4'b0000, 1'b0, 8'h00, 2'd0});
        vt.push_back('{2'd3, 1'b0, 4'b1111, 4'b1000, 1'b1, 8'h3C, 2'd3});
        vt.push_back('{2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0});
        vt.push_back('{2'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10, 2'd0});
        vt.push_back('{2'd2, 1'b0, 4'b1011, 4'b0000, 1'b0, 8'h00, 2'd0});
`ifndef MUX_RR_ARB_EN
        vt.push_back('{2'd0, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h10, 2'd0});
        vt.push_back('{2'd0, 1'b1, 4'b1110, 4'b0000, 1'b0, 8'h00, 2'd0});
        vt.push_back('{2'd3, 1'b1, 4'b1001, 4'b1000, 1'b1, 8'h3C, 2'd3});
`endif

        #2;
        chk("rst_valid_o", 32'(vo4), 32'd0);
        chk("rst_data_o", 32'(dout4), 32'd0);
        chk("rst_chan_o", 32'(chan4), 32'd0);
        chk("rst_ready_o", 32'(rdy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            apply4(vt[i].sel, vt[i].mode, vt[i].valid, 1'b1);
            chk($sformatf("vec%0d_ready_o", i), 32'(rdy4), 32'(vt[i].exp_rdy));
            edge_out();
            chk($sformatf("vec%0d_valid_o", i), 32'(vo4), 32'(vt[i].exp_vo));
            if (vt[i].exp_vo) begin
                chk($sformatf("vec%0d_data_o", i), 32'(dout4), 32'(vt[i].exp_d));
                chk($sformatf("vec%0d_chan_o", i), 32'(chan4), 32'(vt[i].exp_ch));
            end
        end

        // Backpressure: hold 0x11 while stalled, then reload 0x22 once ready_i rises.
        data4[15:8] = 8'h11;
        apply4(2'd1, 1'b0, 4'b0010, 1'b1);
        edge_out();
        chk("bp_load_data", 32'(dout4), 32'h11);
        data4[15:8] = 8'h22;
        apply4(2'd1, 1'b0, 4'b0010, 1'b0);
        chk("bp_stall_ready_o", 32'(rdy4), 32'd0);
        edge_out();
        chk("bp_hold_data", 32'(dout4), 32'h11);
        chk("bp_hold_valid", 32'(vo4), 32'd1);
        apply4(2'd3, 1'b0, 4'b1111, 1'b0);
        edge_out();
        chk("bp_selchg_data", 32'(dout4), 32'h11);
        chk("bp_selchg_chan", 32'(chan4), 32'd1);
        apply4(2'd1, 1'b0, 4'b0010, 1'b1);
        chk("bp_release_ready_o", 32'(rdy4), 32'b0010);
        edge_out();
        chk("bp_new_data", 32'(dout4), 32'h22);
        apply4(2'd1, 1'b0, 4'b0000, 1'b1);
        edge_out();
        chk("drain_valid_o", 32'(vo4), 32'd0);

        // Three-channel instance: select 3 is out of range.
        @(negedge clk);
        sel3   = 2'd3;
        valid3 = 3'b111;
        #1;
        chk("ch3_oob_ready_o", 32'(rdy3), 32'd0);
        edge_out();
        chk("ch3_oob_valid_o", 32'(vo3), 32'd0);
        @(negedge clk);
        sel3 = 2'd2;
        #1;
        chk("ch3_sel2_ready_o", 32'(rdy3), 32'b100);
        edge_out();
        chk("ch3_sel2_data", 32'(dout3), 32'h77);
        chk("ch3_sel2_chan", 32'(chan3), 32'd2);

        // Asynchronous reset drops a held item between clock edges.
        data4[15:8] = 8'h21;
        apply4(2'd2, 1'b0, 4'b0100, 1'b1);
        edge_out();
        apply4(2'd2, 1'b0, 4'b0100, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_o", 32'(vo4), 32'd0);
        chk("async_rst_data_o", 32'(dout4), 32'd0);
        chk("async_rst_ready_o", 32'(rdy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX_RR_ARB_EN
        apply4(2'd0, 1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            edge_out();
            chk($sformatf("rr_seq%0d_chan", i), 32'(chan4), 32'(i % 4));
        end
        apply4(2'd0, 1'b1, 4'b0100, 1'b1);
        chk("rr_p1_ready_o", 32'(rdy4), 32'b0100);
        edge_out();
        apply4(2'd0, 1'b1, 4'b0010, 1'b1);
        chk("rr_p3_ready_o", 32'(rdy4), 32'b0010);
        edge_out();
        chk("rr_p3_chan", 32'(chan4), 32'd1);
        apply4(2'd0, 1'b1, 4'b1111, 1'b0);
        chk("rr_stall_ready_o", 32'(rdy4), 32'd0);
        edge_out();
        apply4(2'd0, 1'b1, 4'b1111, 1'b1);
        chk("rr_p2_ready_o", 32'(rdy4), 32'b0100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_rst_valid_o", 32'(vo4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply4(2'd3, 1'b1, 4'b1111, 1'b1);
        chk("rr_ptr0_ready_o", 32'(rdy4), 32'b0001);
        edge_out();
        chk("rr_ptr0_chan", 32'(chan4), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
